// File: rtl/rsa_pkg.sv
// Shared constants for the RSA encrypt/decrypt cores: operand width,
// multiplier iteration count and the FSM state encoding.
package rsa_pkg;
  localparam int RSA_W    = 16;
  localparam int MM_ITERS = 16;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_REDUCE   = 4'd1;
  localparam state_t ST_REDUCE_W = 4'd2;
  localparam state_t ST_CHECK    = 4'd3;
  localparam state_t ST_MUL      = 4'd4;
  localparam state_t ST_MUL_W    = 4'd5;
  localparam state_t ST_SQR      = 4'd6;
  localparam state_t ST_SQR_W    = 4'd7;
  localparam state_t ST_DONE     = 4'd8;
  localparam state_t ST_ERR      = 4'd9;
endpackage

// File: rtl/rsa_modmul.sv
// Bit-serial MSB-first interleaved modular multiplier: mm_res = a*b mod n.
// Requires a < n; one multiplier bit per cycle, mm_done in the last iteration.
module rsa_modmul
  import rsa_pkg::*;
#(
  parameter int W     = RSA_W,
  parameter int ITERS = MM_ITERS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mm_start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic         mm_done,
  output logic [W-1:0] mm_res
);
  localparam int CW = $clog2(ITERS);

  logic [CW-1:0] cnt_q;
  logic [W:0]    acc_q;
  logic          run_q;
  logic [W:0]    n_ext, dbl, dbl_red, sum, sum_red;

  // Every intermediate stays below 2n, so W+1 bits never overflow.
  always_comb begin
    n_ext   = {1'b0, n};
    dbl     = acc_q << 1;
    dbl_red = (dbl >= n_ext) ? dbl - n_ext : dbl;
    sum     = dbl_red + (b[cnt_q] ? {1'b0, a} : '0);
    sum_red = (sum >= n_ext) ? sum - n_ext : sum;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      acc_q <= '0;
      run_q <= 1'b0;
    end else if (mm_start) begin
      cnt_q <= CW'(ITERS - 1);
      acc_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      acc_q <= sum_red;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) run_q <= 1'b0;
    end
  end

  assign mm_done = run_q && (cnt_q == '0);
  assign mm_res  = sum_red[W-1:0];
endmodule

// File: rtl/rsa_decrypt.sv
// RSA decryption core: dec_val = cipher_val^priv_exp mod modulus using
// right-to-left square-and-multiply over rsa_modmul.
//   IDLE wait start | REDUCE/_W base=c mod n | CHECK inspect e[0]
//   MUL/_W acc*=base | SQR/_W base^2, e>>=1 | DONE publish | ERR n<2
module rsa_decrypt
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] cipher_val,
  input  logic [WIDTH-1:0] priv_exp,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             dec_done,
  output logic [WIDTH-1:0] dec_val,
  output logic             dec_err
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] c_q, e_q, n_q, acc_q, base_q, dec_val_q;
  logic             dec_done_q, dec_err_q, prep_q;
  logic             mm_start, mm_done;
  logic [WIDTH-1:0] mm_a, mm_b, mm_res;
  logic             e_hi_nz, n_small;

  assign e_hi_nz = |e_q[WIDTH-1:1];
  assign n_small = ~|n_q[WIDTH-1:1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start) state_d = (modulus[WIDTH-1:1] == '0) ? ST_ERR : ST_REDUCE;
      ST_ERR:      state_d = ST_DONE;
      ST_REDUCE:   if (prep_q) state_d = ST_REDUCE_W;
      ST_REDUCE_W: if (mm_done) state_d = ST_CHECK;
      ST_CHECK: begin
        if (e_q == '0)   state_d = ST_DONE;
        else if (e_q[0]) state_d = ST_MUL;
        else             state_d = e_hi_nz ? ST_SQR : ST_DONE;
      end
      ST_MUL:      state_d = ST_MUL_W;
      ST_MUL_W:    if (mm_done) state_d = e_hi_nz ? ST_SQR : ST_DONE;
      ST_SQR:      state_d = ST_SQR_W;
      ST_SQR_W:    if (mm_done) state_d = ST_CHECK;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    mm_start = 1'b0;
    mm_a     = '0;
    mm_b     = '0;
    case (state_q)
      ST_REDUCE, ST_REDUCE_W: begin
        mm_a     = WIDTH'(1);
        mm_b     = c_q;
        mm_start = (state_q == ST_REDUCE) && prep_q;
      end
      ST_MUL, ST_MUL_W: begin
        mm_a     = acc_q;
        mm_b     = base_q;
        mm_start = (state_q == ST_MUL);
      end
      ST_SQR, ST_SQR_W: begin
        mm_a     = base_q;
        mm_b     = base_q;
        mm_start = (state_q == ST_SQR);
      end
      default: ;
    endcase
  end

  // REDUCE holds for one extra cycle to seed acc before launching the reduction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_q        <= '0;
      e_q        <= '0;
      n_q        <= '0;
      acc_q      <= '0;
      base_q     <= '0;
      dec_val_q  <= '0;
      dec_done_q <= 1'b0;
      dec_err_q  <= 1'b0;
      prep_q     <= 1'b0;
    end else begin
      prep_q <= (state_q == ST_REDUCE);
      case (state_q)
        ST_IDLE: if (start) begin
          c_q        <= cipher_val;
          e_q        <= priv_exp;
          n_q        <= modulus;
          dec_val_q  <= '0;
          dec_done_q <= 1'b0;
          dec_err_q  <= 1'b0;
        end
        ST_REDUCE:   acc_q <= WIDTH'(1);
        ST_REDUCE_W: if (mm_done) base_q <= mm_res;
        ST_MUL_W:    if (mm_done) acc_q <= mm_res;
        ST_SQR_W: if (mm_done) begin
          base_q <= mm_res;
          e_q    <= e_q >> 1;
        end
        ST_ERR:      acc_q <= '0;
        ST_DONE: begin
          dec_val_q  <= acc_q;
          dec_err_q  <= n_small;
          dec_done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dec_val  = dec_val_q;
  assign dec_done = dec_done_q;
  assign dec_err  = dec_err_q;

  rsa_modmul #(.W(WIDTH), .ITERS(WIDTH)) u_modmul (
    .clk      (clk),
    .rst      (rst),
    .mm_start (mm_start),
    .a        (mm_a),
    .b        (mm_b),
    .n        (n_q),
    .mm_done  (mm_done),
    .mm_res   (mm_res)
  );
endmodule

// File: tb/tb_rsa_decrypt.sv
// Scoreboard bench for rsa_decrypt: expectations from a plain-arithmetic
// modular-exponent model, checked by an independent done monitor.
module tb_rsa_decrypt;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cipher_val = '0, priv_exp = '0, modulus = '0;
  logic        busy, dec_done, dec_err;
  logic [15:0] dec_val;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic mon_prev = 1'b0;

  typedef struct {
    int val;
    int err;
    int acc_cyc;
    int lat;
  } exp_t;

  exp_t sb[$];

  rsa_decrypt dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cipher_val (cipher_val),
    .priv_exp   (priv_exp),
    .modulus    (modulus),
    .busy       (busy),
    .dec_done   (dec_done),
    .dec_val    (dec_val),
    .dec_err    (dec_err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic exp_t model(input int c, input int d, input int n, input int acc);
    exp_t   e;
    longint r, b;
    int     msb, sum;
    e.acc_cyc = acc;
    if (n < 2) begin
      e.val = 0;
      e.err = 1;
      e.lat = 2;
      return e;
    end
    r = 1;
    b = c % n;
    for (int i = 0; i < 16; i++) begin
      if (((d >> i) & 1) != 0) r = (r * b) % n;
      b = (b * b) % n;
    end
    e.val = int'(r);
    e.err = 0;
    if (d == 0) begin
      e.lat = 20;
    end else begin
      msb = 0;
      for (int i = 0; i < 16; i++) if (((d >> i) & 1) != 0) msb = i;
      sum = 0;
      for (int i = 0; i <= msb; i++)
        sum += 1 + 17 * ((d >> i) & 1) + ((i != msb) ? 17 : 0);
      e.lat = 19 + sum;
    end
    return e;
  endfunction

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (dec_done === 1'b1 && mon_prev !== 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got dec_val %0d with no pending request", dec_val);
      end else begin
        e = sb.pop_front();
        chk("dec_val", dec_val, e.val);
        chk("dec_err", dec_err, e.err);
        chk("latency", cyc - e.acc_cyc, e.lat);
        chk("busy_at_done", busy, 0);
      end
    end
    mon_prev = dec_done;
  end

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) begin
      checks++;
      failures++;
      $display("FAIL wait_idle: busy still %0d after %0d cycles", busy, k);
    end
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end
  endtask

  task automatic issue(input int c, input int d, input int n);
    wait_idle();
    cipher_val = 16'(c);
    priv_exp   = 16'(d);
    modulus    = 16'(n);
    start      = 1'b1;
    sb.push_back(model(c, d, n, cyc + 1));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, dec_done, 0);
    chk({tag, "_val"}, dec_val, 0);
    chk({tag, "_err"}, dec_err, 0);
  endtask

  initial begin
    exp_t e1;
    int   k, n_r, d_r;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    issue(3, 7, 33);
    chk("busy_after_accept", busy, 1);
    repeat (60) @(negedge clk);
    chk("busy_mid_run", busy, 1);
    drain();

    issue(2790, 2753, 3233);
    issue(36, 7, 33);
    issue(65534, 65535, 65535);
    issue(5, 0, 33);
    issue(77, 123, 1);
    issue(4, 9, 0);
    drain();

    issue(3, 7, 33);
    repeat (30) @(negedge clk);
    start = 1'b1; cipher_val = 16'd100; priv_exp = 16'd3; modulus = 16'd77;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    cipher_val = 16'd1; priv_exp = 16'd1; modulus = 16'd1;
    drain();

    chk("held_val", dec_val, 9);
    rst = 1'b0;
    #1;
    chk_zero_outputs("rst_idle");
    @(negedge clk);
    rst = 1'b1;

    issue(3, 7, 33);
    repeat (44) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_zero_outputs("rst_sqr_w");
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b1;
    issue(3, 7, 33);
    drain();

    wait_idle();
    cipher_val = 16'd3; priv_exp = 16'd7; modulus = 16'd33;
    start = 1'b1;
    e1 = model(3, 7, 33, cyc + 1);
    sb.push_back(e1);
    @(negedge clk);
    cipher_val = 16'd9;
    sb.push_back(model(9, 7, 33, e1.acc_cyc + 108));
    k = 0;
    while (dec_done !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      checks++;
      failures++;
      $display("FAIL b2b_wait: dec_done %0d after %0d cycles, required 1", dec_done, k);
    end
    @(negedge clk);
    chk("b2b_done_one_cycle", dec_done, 0);
    chk("b2b_busy", busy, 1);
    start = 1'b0;
    drain();

    for (int i = 0; i < 12; i++) begin
      n_r = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(2, 65535));
      d_r = (i % 3 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 65535));
      issue(int'($urandom_range(0, 65535)), d_r, n_r);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rsa_decrypt.md
# rsa_decrypt

Receive-side counterpart of the RSA encryption core: recovers a 16-bit plaintext `dec_val = cipher_val ^ priv_exp mod modulus` by right-to-left square-and-multiply over a bit-serial modular multiplier. Intermediates never exceed 17 bits, so full 16-bit exponents and moduli are supported without an exponent-then-reduce overflow. It sits beside the encryptor and takes captured operands from the same start/done style control.

## Interface
- `WIDTH`, 16: operand width. Cipher, exponent, modulus and result all use this width.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: request. Sampled only in IDLE.
- `cipher_val` input 16: ciphertext. Any value is allowed, including values ≥ `modulus`.
- `priv_exp` input 16: private (decryption) exponent.
- `modulus` input 16: RSA modulus n.
- `busy` output 1: high from the cycle after `start` is accepted until DONE is left.
- `dec_done` output 1: level. Set on completion; held until the next accepted `start`.
- `dec_val` output 16: result. Valid while `dec_done` is high; held until the next accepted `start`.
- `dec_err` output 1: set with `dec_done` when `modulus` < 2.

## Operation
- **Reset** (rst low, any state, async): state→IDLE. `busy`, `dec_done`, `dec_err` = 0. `dec_val` = 0. Datapath registers cleared. Any computation in flight is abandoned.
- **IDLE**: `start`=1 captures `cipher_val`, `priv_exp`, `modulus` into internal registers. It clears `dec_done`, `dec_err` and `dec_val`. Next state:
  - `modulus`<2: ERR.
  - otherwise: REDUCE.
  
  Input changes after capture have no effect. `start` outside IDLE is ignored.
- **ERR**: `dec_val`=0, `dec_err`=1, then DONE.
- **REDUCE / REDUCE_W**: base = modmul(1, c), which yields c mod n. `acc` = 1.
- **CHECK**:
  - If `e`==0: DONE.
  - Else if `e[0]`: MUL.
  - Else: go to the square-or-finish decision (SQR if `e>>1`≠0, else DONE).
- **MUL / MUL_W**: acc = modmul(acc, base). Then SQR if `e>>1`≠0, else DONE.
- **SQR / SQR_W**: base = modmul(base, base), then `e` >>= 1, then CHECK.
- **DONE**: `dec_val` = acc (or 0 if ERR), `dec_done`=1, `busy`=0. Next state IDLE.
- **Exponent 0**: result is 1 (n≥2).
- **Modular multiplier `modmul(a, b)`**:
  - Precondition: a < n.
  - MSB-first interleaved: acc'=0; for i=15..0: t=2·acc' (17 bit), t-=n if t≥n; if b[i], t+=a, t-=n if t≥n; acc'=t.
  - All compares and subtracts are 17-bit. The result is always < n.

## Timing
- Each modmul call takes 17 cycles: 1 launch state plus 16 iterations. The multiplier's `mm_done` is high in its 16th iteration cycle, and the wait state captures on it.
- Accept edge = edge where IDLE samples `start`=1.
- `dec_done` rises N edges after the accept edge, where:
  - N = 1 + 17 + Σ over exponent bits up to MSB of (1 + 17·bit + 17·[not MSB]) + 1.
  - `priv_exp`=0: N=20.
  - `priv_exp`=7: N=107.
- ERR path: `dec_done` 2 edges after accept.
- Back-to-back: `start` high in the same cycle the FSM returns to IDLE is accepted next edge. `dec_done` drops on that edge.

## Structure
- Shared package `rsa_pkg` holds `RSA_W`=16, the FSM state encoding localparams (`ST_IDLE`…`ST_ERR`), and `MM_ITERS`=16. The encryptor adopts the same package.
- One sub-module, `rsa_modmul`:
  - Inputs: `clk`, `rst`, `mm_start`, `a`, `b`, `n`.
  - Outputs: `mm_done`, `mm_res`.
  - Contains the 4-bit iteration counter and the 17-bit accumulator.
- The top level holds the FSM, the exponent shift register, and the `acc`/`base` registers.

## Test plan
1. n=33, d=7, c=3 → `dec_val`=9, `dec_err`=0, `dec_done` 107 edges after accept; `busy` high throughout.
2. n=3233, d=2753, c=2790 → `dec_val`=65. Also cipher ≥ n: n=33, d=7, c=36 → 9.
3. n=65535, d=65535, c=65534 → `dec_val`=65534 (no 17-bit overflow). d=0, c=5, n=33 → 1 at N=20.
4. n=1 or n=0, any c/d → `dec_val`=0, `dec_err`=1, `dec_done` 2 edges after accept.
5. Pulse `start` again and change inputs mid-computation → ignored, result of test 1 unchanged. Assert rst low mid-SQR_W → all outputs 0 immediately. After release, a fresh start with test-1 operands gives 9 at 107 edges.
6. Back-to-back: hold `start` high with new operands (n=33, d=7, c=9 → 15) → first result seen with `dec_done`=1 for exactly one cycle. Second run accepted with no idle gap and produces 15.
